// File: rtl/pack_framer.sv
// pack_framer: collects a sync-marked frame of UART bytes, verifies an 8-bit
// additive checksum and publishes the output/freq patterns and control byte.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | waiting for SYNC_BYTE; all other bytes are dropped
// S_PAYLOAD | shifting PACK_NUM payload bytes into staging, summing them
// S_CHECK   | next byte is the checksum; commit staging or flag an error
module pack_framer #(
    parameter int          DATA_BIT    = 32,
    parameter int          PACK_NUM    = (DATA_BIT / 8) * 2 + 1,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter int          TIMEOUT_CLK = 20000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          i_data,
    input  logic                i_rx_done_tick,
    output logic [DATA_BIT-1:0] o_output_pattern,
    output logic [DATA_BIT-1:0] o_freq_pattern,
    output logic [7:0]          o_ctrl,
    output logic                o_pack_valid,
    output logic                o_chk_err,
    output logic                o_timeout,
    output logic                o_busy,
    output logic [7:0]          o_pack_cnt
);

    localparam int STAGE_W = PACK_NUM * 8;
    localparam int IDX_W   = (PACK_NUM > 1) ? $clog2(PACK_NUM) : 1;
    localparam int TMO_W   = (TIMEOUT_CLK > 1) ? $clog2(TIMEOUT_CLK) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PACK_NUM - 1);
    // The inter-byte timer counts down from TIMEOUT_CLK-1; reaching zero with
    // no byte is the same instant an up-counter would hit TIMEOUT_CLK-1.
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CLK - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PAYLOAD = 2'd1,
        S_CHECK   = 2'd2
    } state_t;

    state_t               state_q;
    logic [IDX_W-1:0]     idx_q;
    logic [7:0]           sum_q;
    logic [TMO_W-1:0]     tmo_q;
    logic [STAGE_W-1:0]   stage_q;

    logic [DATA_BIT-1:0]  out_pat_q;
    logic [DATA_BIT-1:0]  freq_pat_q;
    logic [7:0]           ctrl_q;
    logic                 pack_valid_q;
    logic                 chk_err_q;
    logic                 timeout_q;
    logic [7:0]           pack_cnt_q;

    logic [STAGE_W-1:0]   stage_d;
    logic [7:0]           sum_d;
    logic                 tmo_hit;

    // Bytes enter at the top so byte 0 ends up in the lowest lane.
    always_comb begin
        stage_d = {i_data, stage_q[STAGE_W-1:8]};
        sum_d   = sum_q + i_data;
        tmo_hit = (tmo_q == '0);
    end

    // Frame sequencer: byte consumption, checksum commit and timeout abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            sum_q        <= '0;
            tmo_q        <= '0;
            stage_q      <= '0;
            out_pat_q    <= '0;
            freq_pat_q   <= '0;
            ctrl_q       <= '0;
            pack_valid_q <= 1'b0;
            chk_err_q    <= 1'b0;
            timeout_q    <= 1'b0;
            pack_cnt_q   <= '0;
        end else begin
            pack_valid_q <= 1'b0;
            chk_err_q    <= 1'b0;
            timeout_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_rx_done_tick && (i_data == SYNC_BYTE)) begin
                        state_q <= S_PAYLOAD;
                        idx_q   <= '0;
                        sum_q   <= '0;
                        tmo_q   <= TMO_LOAD;
                    end
                end
                S_PAYLOAD: begin
                    // A byte always beats the timer, even on the terminal clock.
                    if (i_rx_done_tick) begin
                        stage_q <= stage_d;
                        sum_q   <= sum_d;
                        tmo_q   <= TMO_LOAD;
                        idx_q   <= idx_q + IDX_W'(1);
                        if (idx_q == IDX_LAST) begin
                            state_q <= S_CHECK;
                        end
                    end else if (tmo_hit) begin
                        timeout_q <= 1'b1;
                        stage_q   <= '0;
                        state_q   <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_q - TMO_W'(1);
                    end
                end
                S_CHECK: begin
                    if (i_rx_done_tick) begin
                        tmo_q   <= TMO_LOAD;
                        state_q <= S_IDLE;
                        if (i_data == sum_q) begin
                            out_pat_q    <= stage_q[DATA_BIT-1:0];
                            freq_pat_q   <= stage_q[2*DATA_BIT-1:DATA_BIT];
                            ctrl_q       <= stage_q[2*DATA_BIT +: 8];
                            pack_valid_q <= 1'b1;
                            pack_cnt_q   <= pack_cnt_q + 8'd1;
                        end else begin
                            chk_err_q <= 1'b1;
                        end
                    end else if (tmo_hit) begin
                        timeout_q <= 1'b1;
                        stage_q   <= '0;
                        state_q   <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_q - TMO_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Busy simply reflects the registered state; all other outputs are registers.
    always_comb begin
        o_busy = (state_q != S_IDLE);
    end

    assign o_output_pattern = out_pat_q;
    assign o_freq_pattern   = freq_pat_q;
    assign o_ctrl           = ctrl_q;
    assign o_pack_valid     = pack_valid_q;
    assign o_chk_err        = chk_err_q;
    assign o_timeout        = timeout_q;
    assign o_pack_cnt       = pack_cnt_q;

endmodule

// File: tb/tb_pack_framer.sv
// Bench for pack_framer: table of frames plus hand-written sequences for
// timeout, mid-frame reset and counter wrap; pulses are checked against a
// queue of expected events built from the bench's own model.
module tb_pack_framer;

    localparam int TMO = 64;
    localparam int K_VALID = 0;
    localparam int K_CHK   = 1;
    localparam int K_TMO   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  i_data = 8'h00;
    logic        i_rx_done_tick = 1'b0;
    logic [31:0] o_output_pattern;
    logic [31:0] o_freq_pattern;
    logic [7:0]  o_ctrl;
    logic        o_pack_valid;
    logic        o_chk_err;
    logic        o_timeout;
    logic        o_busy;
    logic [7:0]  o_pack_cnt;

    pack_framer #(
        .DATA_BIT    (32),
        .SYNC_BYTE   (8'hA5),
        .TIMEOUT_CLK (TMO)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .i_data           (i_data),
        .i_rx_done_tick   (i_rx_done_tick),
        .o_output_pattern (o_output_pattern),
        .o_freq_pattern   (o_freq_pattern),
        .o_ctrl           (o_ctrl),
        .o_pack_valid     (o_pack_valid),
        .o_chk_err        (o_chk_err),
        .o_timeout        (o_timeout),
        .o_busy           (o_busy),
        .o_pack_cnt       (o_pack_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          kind;
        logic [31:0] out_p;
        logic [31:0] freq_p;
        logic [7:0]  ctrl;
        logic [7:0]  cnt;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [8:0][7:0] pl;      // pl[0] is the first payload byte
        logic [7:0]      x;       // xor applied to the correct checksum
        bit              lead;    // send 00 FF 11 before the sync byte
        int              gap_at;  // idle clocks inserted before this byte index
        int              gap_len;
        logic [31:0]     e_out;
        logic [31:0]     e_freq;
        logic [7:0]      e_ctrl;
    } vec_t;

    exp_t        sb[$];
    vec_t        vt[6];
    int          total = 0;
    int          bad = 0;
    int          last_cyc = 0;
    logic [31:0] m_out = '0;
    logic [31:0] m_freq = '0;
    logic [7:0]  m_ctrl = '0;
    logic [7:0]  m_cnt = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Call at a falling edge; the byte is consumed on the following rising edge.
    task automatic send_byte(input logic [7:0] b);
        i_data = b;
        i_rx_done_tick = 1'b1;
        last_cyc = cyc + 1;
        @(negedge clk);
        i_rx_done_tick = 1'b0;
    endtask

    task automatic send_frame(input logic [8:0][7:0] pl, input logic [7:0] x,
                              input int gap_at, input int gap_len);
        logic [7:0] s;
        exp_t e;
        s = 8'h00;
        send_byte(8'hA5);
        for (int i = 0; i < 9; i++) begin
            if (i == gap_at) repeat (gap_len) @(negedge clk);
            s = s + pl[i];
            send_byte(pl[i]);
        end
        if (gap_at == 9) repeat (gap_len) @(negedge clk);
        if (x == 8'h00) begin
            m_out  = {pl[3], pl[2], pl[1], pl[0]};
            m_freq = {pl[7], pl[6], pl[5], pl[4]};
            m_ctrl = pl[8];
            m_cnt  = m_cnt + 8'd1;
            e.kind = K_VALID;
        end else begin
            e.kind = K_CHK;
        end
        e.out_p  = m_out;
        e.freq_p = m_freq;
        e.ctrl   = m_ctrl;
        e.cnt    = m_cnt;
        e.cyc    = cyc + 1;
        sb.push_back(e);
        send_byte(s ^ x);
    endtask

    // Event monitor: every status pulse must match the oldest pending event.
    always @(negedge clk) begin
        if (!rst && (o_pack_valid || o_chk_err || o_timeout)) begin
            exp_t e;
            int   k;
            int   n;
            n = int'(o_pack_valid) + int'(o_chk_err) + int'(o_timeout);
            k = o_pack_valid ? K_VALID : (o_chk_err ? K_CHK : K_TMO);
            chk("pulse_exclusive", n, 1);
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse: got kind %0d, expected no event (cycle %0d)", k, cyc);
            end else begin
                e = sb.pop_front();
                chk("event_kind", k, e.kind);
                chk("event_latency", cyc, e.cyc);
                chk("event_out", o_output_pattern, e.out_p);
                chk("event_freq", o_freq_pattern, e.freq_p);
                chk("event_ctrl", o_ctrl, e.ctrl);
                chk("event_cnt", o_pack_cnt, e.cnt);
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_out"},   o_output_pattern, 0);
        chk({tag, "_freq"},  o_freq_pattern, 0);
        chk({tag, "_ctrl"},  o_ctrl, 0);
        chk({tag, "_cnt"},   o_pack_cnt, 0);
        chk({tag, "_busy"},  o_busy, 0);
        chk({tag, "_valid"}, o_pack_valid, 0);
        chk({tag, "_err"},   o_chk_err, 0);
        chk({tag, "_tmo"},   o_timeout, 0);
    endtask

    initial begin
        logic [8:0][7:0] rp;
        exp_t te;

        // Payload bytes are listed last-to-first inside each concatenation.
        vt[0] = '{{8'h01, 8'h00, 8'h00, 8'h00, 8'h0F, 8'h12, 8'h34, 8'h56, 8'h78},
                  8'h00, 1'b0, -1, 0, 32'h12345678, 32'h0000000F, 8'h01};
        vt[1] = '{{8'h01, 8'h00, 8'h00, 8'h00, 8'h0F, 8'h12, 8'h34, 8'h56, 8'h78},
                  8'h01, 1'b0, -1, 0, 32'h12345678, 32'h0000000F, 8'h01};
        vt[2] = '{{8'hA5, 8'h44, 8'h33, 8'h22, 8'h11, 8'hFF, 8'h00, 8'hA5, 8'hA5},
                  8'h00, 1'b1, 3, 2, 32'hFF00A5A5, 32'h44332211, 8'hA5};
        vt[3] = '{{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF},
                  8'h00, 1'b0, -1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'hFF};
        vt[4] = '{{8'h09, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01},
                  8'h80, 1'b0, -1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'hFF};
        vt[5] = '{{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                  8'h00, 1'b0, 9, 5, 32'h00000000, 32'h00000000, 8'h00};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_all_zero("reset");

        for (int i = 0; i < 6; i++) begin
            if (vt[i].lead) begin
                send_byte(8'h00);
                send_byte(8'hFF);
                send_byte(8'h11);
                chk("lead_ignored_busy", o_busy, 0);
            end
            send_frame(vt[i].pl, vt[i].x, vt[i].gap_at, vt[i].gap_len);
            @(negedge clk);
            chk($sformatf("vec%0d_out", i),  o_output_pattern, vt[i].e_out);
            chk($sformatf("vec%0d_freq", i), o_freq_pattern, vt[i].e_freq);
            chk($sformatf("vec%0d_ctrl", i), o_ctrl, vt[i].e_ctrl);
            chk($sformatf("vec%0d_busy", i), o_busy, 0);
        end
        chk("table_cnt", o_pack_cnt, 4);

        // Inter-byte timeout after four payload bytes.
        send_byte(8'hA5);
        send_byte(8'hDE);
        send_byte(8'hAD);
        send_byte(8'hBE);
        send_byte(8'hEF);
        chk("partial_busy", o_busy, 1);
        te.kind = K_TMO; te.out_p = m_out; te.freq_p = m_freq;
        te.ctrl = m_ctrl; te.cnt = m_cnt; te.cyc = last_cyc + TMO;
        sb.push_back(te);
        repeat (TMO + 4) @(negedge clk);
        chk("timeout_busy", o_busy, 0);
        send_frame(vt[0].pl, 8'h00, -1, 0);
        @(negedge clk);
        chk("after_tmo_out", o_output_pattern, 32'h12345678);
        chk("after_tmo_cnt", o_pack_cnt, 5);

        // Reset in the middle of a frame, after its sixth byte.
        send_byte(8'hA5);
        for (int i = 0; i < 5; i++) send_byte(8'h10 + 8'(i));
        chk("midframe_busy", o_busy, 1);
        rst = 1'b1;
        #1;
        chk_all_zero("midreset");
        m_out = '0; m_freq = '0; m_ctrl = '0; m_cnt = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_frame(vt[2].pl, 8'h00, -1, 0);
        @(negedge clk);
        chk("post_reset_cnt", o_pack_cnt, 1);
        chk("post_reset_out", o_output_pattern, 32'hFF00A5A5);

        // 255 more valid frames wrap the counter; two frames carry a byte
        // landing exactly on the timer's terminal clock.
        for (int f = 0; f < 255; f++) begin
            for (int b = 0; b < 9; b++) rp[b] = 8'($urandom_range(0, 255));
            if (f == 100)      send_frame(rp, 8'h00, 4, TMO - 1);
            else if (f == 150) send_frame(rp, 8'h00, 9, TMO - 1);
            else               send_frame(rp, 8'h00, -1, 0);
        end
        repeat (2) @(negedge clk);
        chk("wrap_cnt", o_pack_cnt, 0);
        chk("wrap_busy", o_busy, 0);

        repeat (4) @(negedge clk);
        chk("events_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
